// File: rtl/sync_delay_ctrl.sv
// rtl/sync_delay_ctrl.sv - frame-synchronous programmable delay line for {vs, hs, de}
// New delays take effect at an input frame boundary; outputs idle while the buffer refills.
module sync_delay_ctrl #(
   parameter int   MAX_DELAY     = 16,
   parameter int   DEFAULT_DELAY = 2,
   parameter logic SYNC_POL      = 1'b1,
   parameter int   DW            = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          de_in,
   input  logic          hs_in,
   input  logic          vs_in,
   input  logic          cfg_valid,
   input  logic [DW-1:0] cfg_delay,
   output logic          cfg_ready,
   output logic          cfg_err,
   output logic          de_out,
   output logic          hs_out,
   output logic          vs_out,
   output logic [DW-1:0] cur_delay,
   output logic          busy
);

   localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

   typedef enum logic [1:0] {S_RUN, S_PEND, S_FLUSH} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    mem [MAX_DELAY];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [DW:0]   wp_ext;
   logic [DW:0]   lag_ext;
   logic [2:0]    tap;
   logic          vs_prev;
   logic          frame_start;
   logic          req_ok;
   logic          accept;
   logic [DW-1:0] pend_delay;
   logic [DW-1:0] flush_cnt;

   always_ff @(posedge clk) begin
      mem[wr_ptr] <= {vs_in, hs_in, de_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         vs_prev <= ~SYNC_POL;
      end else begin
         wr_ptr  <= (wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr + PW'(1);
         vs_prev <= vs_in;
      end
   end

   // Registered outputs: a delay of d reads the sample written d-1 cycles ago; d = 1 bypasses the buffer.
   assign wp_ext  = (DW+1)'(wr_ptr);
   assign lag_ext = (DW+1)'(cur_delay) - (DW+1)'(1);
   assign rd_ptr  = (wp_ext >= lag_ext) ? PW'(wp_ext - lag_ext)
                                        : PW'(wp_ext + (DW+1)'(MAX_DELAY) - lag_ext);
   assign tap     = (cur_delay == DW'(1)) ? {vs_in, hs_in, de_in} : mem[rd_ptr];

   assign frame_start = (vs_prev == ~SYNC_POL) && (vs_in == SYNC_POL);
   assign req_ok      = (cfg_delay != '0) && (cfg_delay <= DW'(MAX_DELAY));
   assign accept      = cfg_valid && cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FLUSH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:   if (accept && req_ok) state_nxt = S_PEND;
         S_PEND:  if (frame_start) state_nxt = S_FLUSH;
         S_FLUSH: if (flush_cnt <= DW'(1)) state_nxt = S_RUN;
         default: state_nxt = S_FLUSH;
      endcase
   end

   // Ready is withheld while an error pulse is out so a reject and an accept never coincide.
   always_comb begin
      cfg_ready = (state == S_RUN) && !cfg_err;
      busy      = (state != S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_delay  <= DW'(DEFAULT_DELAY);
         pend_delay <= DW'(DEFAULT_DELAY);
         flush_cnt  <= DW'(DEFAULT_DELAY);
         cfg_err    <= 1'b0;
         de_out     <= 1'b0;
         hs_out     <= ~SYNC_POL;
         vs_out     <= ~SYNC_POL;
      end else begin
         cfg_err <= accept && !req_ok;
         if (accept && req_ok) pend_delay <= cfg_delay;
         if (state == S_PEND && frame_start) begin
            cur_delay <= pend_delay;
            flush_cnt <= pend_delay;
         end else if (state == S_FLUSH && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - DW'(1);
         end
         if (state_nxt == S_FLUSH) begin
            de_out <= 1'b0;
            hs_out <= ~SYNC_POL;
            vs_out <= ~SYNC_POL;
         end else begin
            {vs_out, hs_out, de_out} <= tap;
         end
      end
   end

endmodule

// File: tb/tb_sync_delay_ctrl.sv
// tb/tb_sync_delay_ctrl.sv - bench for sync_delay_ctrl
// Inputs driven and outputs sampled on the falling edge; expected samples held in a queue.
module tb_sync_delay_ctrl;

   localparam int MAXD   = 16;
   localparam int DW     = 5;
   localparam int F      = 40;
   localparam int M_NONE = 0;
   localparam int M_IDLE = 1;
   localparam int M_DATA = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0, cfg_valid = 1'b0;
   logic [DW-1:0] cfg_delay = '0;
   logic          cfg_ready, cfg_err, de_out, hs_out, vs_out, busy;
   logic [DW-1:0] cur_delay;

   logic          de_b = 1'b0, hs_b = 1'b1, vs_b = 1'b1, cfg_valid_b = 1'b0;
   logic [DW-1:0] cfg_delay_b = '0;
   logic          cfg_ready_b, cfg_err_b, de_out_b, hs_out_b, vs_out_b, busy_b;
   logic [DW-1:0] cur_delay_b;

   int         errors = 0;
   int         checks = 0;
   int         pos = 5;
   int         d_exp = 2;
   logic [2:0] sb_q[$];

   always #5 clk = ~clk;

   sync_delay_ctrl #(.MAX_DELAY(MAXD), .DEFAULT_DELAY(2), .SYNC_POL(1'b1), .DW(DW)) u_dut (
      .clk(clk), .rst_n(rst_n), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
      .cfg_valid(cfg_valid), .cfg_delay(cfg_delay), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out), .cur_delay(cur_delay), .busy(busy));

   sync_delay_ctrl #(.MAX_DELAY(MAXD), .DEFAULT_DELAY(2), .SYNC_POL(1'b0), .DW(DW)) u_dut_neg (
      .clk(clk), .rst_n(rst_n), .de_in(de_b), .hs_in(hs_b), .vs_in(vs_b),
      .cfg_valid(cfg_valid_b), .cfg_delay(cfg_delay_b), .cfg_ready(cfg_ready_b), .cfg_err(cfg_err_b),
      .de_out(de_out_b), .hs_out(hs_out_b), .vs_out(vs_out_b), .cur_delay(cur_delay_b), .busy(busy_b));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One pixel cycle: check the current output, then drive and record the next input vector.
   task automatic cyc(input int mode);
      logic [2:0] got;
      logic [2:0] exp_v;
      logic [2:0] vec;
      got = {vs_out, hs_out, de_out};
      while (sb_q.size() > MAXD) void'(sb_q.pop_front());
      if (mode == M_IDLE) begin
         checks++;
         if (got !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle pos=%0d: got vhd=%b busy=%b, expected vhd=000 busy=1", pos, got, busy);
         end
      end else if (mode == M_DATA) begin
         while (sb_q.size() > d_exp) void'(sb_q.pop_front());
         if (sb_q.size() == d_exp) begin
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL delayed_data d=%0d pos=%0d: got vhd=%b, expected vhd=%b", d_exp, pos, got, exp_v);
            end
         end
      end
      vec[2] = (pos < 3);
      vec[1] = ((pos % 10) < 2);
      vec[0] = 1'($urandom_range(0, 1));
      {vs_in, hs_in, de_in} = vec;
      sb_q.push_back(vec);
      pos = (pos + 1) % F;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin
         cyc(M_NONE);
         checks++;
         if ({de_out, hs_out, vs_out, cfg_ready, cfg_err, busy} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_outputs: got de,hs,vs,rdy,err,busy=%b, expected 000001",
                     {de_out, hs_out, vs_out, cfg_ready, cfg_err, busy});
         end
         checks++;
         if (cur_delay !== 5'd2) begin
            errors++;
            $display("FAIL reset_cur_delay: got %0d, expected 2", cur_delay);
         end
      end
      rst_n = 1'b1;
      sb_q.delete();
      d_exp = 2;
      cyc(M_IDLE);
      cyc(M_IDLE);
      checks++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1 || cur_delay !== 5'd2) begin
         errors++;
         $display("FAIL reset_to_run: got busy=%b rdy=%b cur=%0d, expected 0 1 2", busy, cfg_ready, cur_delay);
      end
      repeat (30) cyc(M_DATA);
   endtask

   task automatic test_invalid();
      logic [DW-1:0] bad [2];
      bad[0] = 5'd0;
      bad[1] = 5'd17;
      for (int i = 0; i < 2; i++) begin
         cfg_valid = 1'b1;
         cfg_delay = bad[i];
         checks++;
         if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_pre req=%0d: got rdy=%b err=%b, expected 1 0", bad[i], cfg_ready, cfg_err);
         end
         cyc(M_DATA);
         cfg_valid = 1'b0;
         checks++;
         if (cfg_err !== 1'b1 || busy !== 1'b0 || cur_delay !== 5'd2) begin
            errors++;
            $display("FAIL invalid_err req=%0d: got err=%b busy=%b cur=%0d, expected 1 0 2", bad[i], cfg_err, busy, cur_delay);
         end
         cyc(M_DATA);
         checks++;
         if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_pulse req=%0d: got err=%b, expected 0", bad[i], cfg_err);
         end
      end
      repeat (45) begin
         cyc(M_DATA);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_no_change: got busy=%b, expected 0", busy);
         end
      end
   endtask

   task automatic test_change();
      while (pos != 15) cyc(M_DATA);
      cfg_valid = 1'b1;
      cfg_delay = 5'd7;
      cyc(M_DATA);
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0 || busy !== 1'b1 || cur_delay !== 5'd2) begin
         errors++;
         $display("FAIL change_pend: got rdy=%b busy=%b cur=%0d, expected 0 1 2", cfg_ready, busy, cur_delay);
      end
      while (pos != 0) cyc(M_DATA);
      cyc(M_DATA);
      checks++;
      if (cur_delay !== 5'd7) begin
         errors++;
         $display("FAIL change_cur_delay: got %0d, expected 7", cur_delay);
      end
      repeat (7) cyc(M_IDLE);
      d_exp = 7;
      checks++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL change_run: got busy=%b rdy=%b, expected 0 1", busy, cfg_ready);
      end
      repeat (25) cyc(M_DATA);
   endtask

   task automatic test_back_to_back_boundary();
      while (pos != 0) cyc(M_DATA);
      cfg_valid = 1'b1;
      cfg_delay = 5'd16;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL wrap_ready: got %b, expected 1", cfg_ready);
      end
      cyc(M_DATA);
      cfg_valid = 1'b0;
      while (pos != 0) cyc(M_DATA);
      checks++;
      if (busy !== 1'b1 || cur_delay !== 5'd7) begin
         errors++;
         $display("FAIL wrap_deferred: got busy=%b cur=%0d, expected 1 7", busy, cur_delay);
      end
      cyc(M_DATA);
      repeat (16) cyc(M_IDLE);
      d_exp = 16;
      checks++;
      if (busy !== 1'b0 || cur_delay !== 5'd16) begin
         errors++;
         $display("FAIL wrap_run: got busy=%b cur=%0d, expected 0 16", busy, cur_delay);
      end
      repeat (40) cyc(M_DATA);
   endtask

   task automatic test_reset_flush();
      while (pos != 20) cyc(M_DATA);
      cfg_valid = 1'b1;
      cfg_delay = 5'd7;
      cyc(M_DATA);
      cfg_valid = 1'b0;
      while (pos != 0) cyc(M_DATA);
      cyc(M_DATA);
      repeat (3) cyc(M_IDLE);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({de_out, hs_out, vs_out, cfg_ready, busy} !== 5'b00001 || cur_delay !== 5'd2) begin
         errors++;
         $display("FAIL midflush_reset: got de,hs,vs,rdy,busy=%b cur=%0d, expected 00001 2",
                  {de_out, hs_out, vs_out, cfg_ready, busy}, cur_delay);
      end
      cyc(M_NONE);
      cyc(M_NONE);
      rst_n = 1'b1;
      sb_q.delete();
      d_exp = 2;
      cyc(M_IDLE);
      cyc(M_IDLE);
      repeat (45) begin
         cyc(M_DATA);
         checks++;
         if (busy !== 1'b0 || cur_delay !== 5'd2) begin
            errors++;
            $display("FAIL midflush_no_stale: got busy=%b cur=%0d, expected 0 2", busy, cur_delay);
         end
      end
   endtask

   task automatic test_polarity();
      vs_b = 1'b1; hs_b = 1'b1; de_b = 1'b0;
      rst_n = 1'b0;
      tick();
      checks++;
      if ({de_out_b, hs_out_b, vs_out_b, busy_b} !== 4'b0111) begin
         errors++;
         $display("FAIL neg_reset_idle: got de,hs,vs,busy=%b, expected 0111", {de_out_b, hs_out_b, vs_out_b, busy_b});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({de_out_b, hs_out_b, vs_out_b, busy_b} !== 4'b0111) begin
            errors++;
            $display("FAIL neg_flush_idle c=%0d: got de,hs,vs,busy=%b, expected 0111", i, {de_out_b, hs_out_b, vs_out_b, busy_b});
         end
         tick();
      end
      checks++;
      if (busy_b !== 1'b0) begin
         errors++;
         $display("FAIL neg_run: got busy=%b, expected 0", busy_b);
      end
      vs_b = 1'b0;
      tick();
      tick();
      cfg_valid_b = 1'b1;
      cfg_delay_b = 5'd3;
      checks++;
      if (cfg_ready_b !== 1'b1) begin
         errors++;
         $display("FAIL neg_ready: got %b, expected 1", cfg_ready_b);
      end
      tick();
      cfg_valid_b = 1'b0;
      vs_b = 1'b1;
      repeat (3) tick();
      checks++;
      if (busy_b !== 1'b1 || cur_delay_b !== 5'd2) begin
         errors++;
         $display("FAIL neg_rise_ignored: got busy=%b cur=%0d, expected 1 2", busy_b, cur_delay_b);
      end
      vs_b = 1'b0; hs_b = 1'b0; de_b = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({de_out_b, hs_out_b, vs_out_b, busy_b} !== 4'b0111 || cur_delay_b !== 5'd3) begin
            errors++;
            $display("FAIL neg_fall_flush c=%0d: got de,hs,vs,busy=%b cur=%0d, expected 0111 3",
                     i, {de_out_b, hs_out_b, vs_out_b, busy_b}, cur_delay_b);
         end
         tick();
      end
      checks++;
      if ({de_out_b, hs_out_b, vs_out_b, busy_b} !== 4'b1000) begin
         errors++;
         $display("FAIL neg_delayed: got de,hs,vs,busy=%b, expected 1000", {de_out_b, hs_out_b, vs_out_b, busy_b});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_invalid();
      test_change();
      test_back_to_back_boundary();
      test_reset_flush();
      test_polarity();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
